// File: rtl/tqvp_pwm_capture.sv
// PWM capture peripheral: measures high time and period of a selected ui_in pin in prescaled
// ticks and reports completed measurements through registers and an interrupt.
module tqvp_pwm_capture #(
    parameter int unsigned CW = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StHigh = 2'd2,
        StLow  = 2'd3
    } state_e;

    localparam logic [CW-1:0] CntMax = '1;

    state_e        state_q, state_d;
    logic          en_q, en_d, cont_q, cont_d, inv_q, inv_d, ie_q, ie_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    presc_q, presc_d;
    logic          valid_q, valid_d, ovr_q, ovr_d, timeout_q, timeout_d;
    logic          s_prev_q;
    logic [7:0]    pre_q, pre_d;
    logic [CW-1:0] cnt_q, cnt_d, high_cap_q, high_cap_d, high_q, high_d, period_q, period_d;

    logic          s, rise, fall, tick, running, sat_tick;
    logic [CW-1:0] cnt_now;
    logic          addr_ok, wr_en, wr_ctrl, wr_stat, wr_wide, rd_en;
    logic [2:0]    clr;
    logic          set_valid, set_ovr, set_to, en_clr;
    logic          unused_bits;

    assign s    = ui_in[sel_q] ^ inv_q;
    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;

    assign running  = (state_q == StHigh) || (state_q == StLow);
    assign tick     = (pre_q == presc_q);
    assign sat_tick = tick && (cnt_q == CntMax);
    // Counter value as it will be after this cycle's tick, used for same-cycle captures.
    assign cnt_now  = (tick && (cnt_q != CntMax)) ? cnt_q + CW'(1) : cnt_q;

    assign addr_ok = (address[5:4] == 2'b00);
    assign wr_en   = (data_write_n != 2'b11) && addr_ok;
    assign wr_ctrl = wr_en && (address[3:2] == 2'd0);
    assign wr_stat = wr_en && (address[3:2] == 2'd1);
    assign wr_wide = (data_write_n != 2'b00);
    assign rd_en   = (data_read_n != 2'b11);

    assign data_ready     = rd_en;
    assign user_interrupt = ie_q & (valid_q | timeout_q);
    assign uo_out         = {s, valid_q, 6'b0};
    assign unused_bits    = ^{address[1:0], data_in[31:16], data_in[7]};

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        cont_d     = cont_q;
        inv_d      = inv_q;
        ie_d       = ie_q;
        sel_d      = sel_q;
        presc_d    = presc_q;
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        high_cap_d = high_cap_q;
        high_d     = high_q;
        period_d   = period_q;
        set_valid  = 1'b0;
        set_ovr    = 1'b0;
        set_to     = 1'b0;
        en_clr     = 1'b0;
        clr        = wr_stat ? data_in[2:0] : 3'b000;

        if (running) begin
            pre_d = tick ? 8'd0 : pre_q + 8'd1;
            cnt_d = cnt_now;
        end

        case (state_q)
            StIdle: ;
            StArm: begin
                if (rise) begin
                    state_d = StHigh;
                    pre_d   = 8'd0;
                    cnt_d   = '0;
                end
            end
            StHigh, StLow: begin
                if (sat_tick) begin
                    set_to  = 1'b1;
                    state_d = cont_q ? StArm : StIdle;
                    en_clr  = ~cont_q;
                end else if (state_q == StHigh && fall) begin
                    high_cap_d = cnt_now;
                    state_d    = StLow;
                end else if (state_q == StLow && rise) begin
                    high_d    = high_cap_q;
                    period_d  = cnt_now;
                    set_valid = 1'b1;
                    set_ovr   = valid_q;
                    // The closing rise doubles as the opening rise of the next period.
                    if (cont_q) begin
                        state_d = StHigh;
                        pre_d   = 8'd0;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                        en_clr  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        en_d = en_q & ~en_clr;

        if (wr_ctrl) begin
            en_d   = data_in[0];
            cont_d = data_in[1];
            inv_d  = data_in[2];
            ie_d   = data_in[3];
            sel_d  = data_in[6:4];
            if (wr_wide) begin
                presc_d = data_in[15:8];
            end
            if (!data_in[0]) begin
                // Disabling aborts any measurement without touching flags or results.
                state_d   = StIdle;
                set_valid = 1'b0;
                set_ovr   = 1'b0;
                set_to    = 1'b0;
                high_d    = high_q;
                period_d  = period_q;
            end else if (!en_q) begin
                state_d = StArm;
            end
        end

        valid_d   = (valid_q & ~clr[0]) | set_valid;
        ovr_d     = (ovr_q & ~clr[1]) | set_ovr;
        timeout_d = (timeout_q & ~clr[2]) | set_to;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            cont_q     <= 1'b0;
            inv_q      <= 1'b0;
            ie_q       <= 1'b0;
            sel_q      <= 3'd0;
            presc_q    <= 8'd0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            timeout_q  <= 1'b0;
            s_prev_q   <= 1'b0;
            pre_q      <= 8'd0;
            cnt_q      <= '0;
            high_cap_q <= '0;
            high_q     <= '0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            cont_q     <= cont_d;
            inv_q      <= inv_d;
            ie_q       <= ie_d;
            sel_q      <= sel_d;
            presc_q    <= presc_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            timeout_q  <= timeout_d;
            s_prev_q   <= s;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            high_cap_q <= high_cap_d;
            high_q     <= high_d;
            period_q   <= period_d;
        end
    end

    always_comb begin
        data_out = 32'd0;
        if (rd_en && addr_ok) begin
            case (address[3:2])
                2'd0:    data_out = {16'h0, presc_q, 1'b0, sel_q, ie_q, inv_q, cont_q, en_q};
                2'd1:    data_out = {27'h0, state_q, timeout_q, ovr_q, valid_q};
                2'd2:    data_out = 32'(high_q);
                default: data_out = 32'(period_q);
            endcase
        end
    end

endmodule

// File: doc/tqvp_pwm_capture.md
# tqvp_pwm_capture

PWM capture peripheral for the TinyQV peripheral bus: the receiving end of the PWM/timer block. It measures the high time and period of a PWM waveform arriving on a selectable `ui_in` pin, in prescaled clock ticks. It reports each completed measurement through memory-mapped registers and the dedicated interrupt line. It sits beside the PWM/timer/counter peripheral, so firmware can loop one block's output back and check duty and frequency.

## Interface
- `CW`, 24: measurement counter width; legal range 8..32; register reads zero-extend to 32 bits.
- `clk`  in  1  peripheral clock (64 MHz nominal).
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ui_in`  in  8  input PMOD, already synchronized upstream; the capture pin is selected by CTRL.SEL.
- `uo_out`  out  8  [7] = conditioned capture input, [6] = STATUS.VALID, [5:0] = 0.
- `address`  in  6  register offset; [5:4] must be 0, [3:2] selects the register.
- `data_in`  in  32  write data.
- `data_write_n`  in  2  11 = none, 00 = byte (updates [7:0]), 01 = half (updates [15:0]), 10 = word.
- `data_read_n`  in  2  11 = none, otherwise read.
- `data_out`  out  32  read data; 0 when no read is active or the address is unmapped.
- `data_ready`  out  1  combinational: 1 whenever `data_read_n` != 11.
- `user_interrupt`  out  1  CTRL.IE & (VALID | TIMEOUT).

## Operation
- **Registers**
  - 0x00 CTRL (R/W): [0] EN, [1] CONT, [2] INV, [3] IE, [6:4] SEL, [15:8] PRESC.
  - 0x04 STATUS: [0] VALID, [1] OVR, [2] TIMEOUT, [4:3] state. Flags are write-1-to-clear.
  - 0x08 HIGH (RO).
  - 0x0C PERIOD (RO). Writes to HIGH and PERIOD are ignored.
- **Input conditioning and edge detect**
  - s = ui_in[SEL] ^ INV; s_prev is registered every cycle.
  - rise = s & ~s_prev; fall = ~s & s_prev.
- **Prescaler and counter**
  - Prescaler counts 0..PRESC. tick = (prescaler == PRESC).
  - At a rise that starts a measurement, the prescaler and counter load 0.
  - The counter increments on each tick. It saturates at 2^CW-1.
- **FSM states**
  - IDLE=0: waits for EN rising (0->1 on a CTRL write), then goes to ARM.
  - ARM=1: on rise -> HIGH, counter and prescaler load 0.
  - HIGH=2: on fall -> HIGH_reg <= counter value including the same-cycle tick, then LOW.
  - LOW=3: on rise -> PERIOD_reg <= counter including the same-cycle tick; HIGH and PERIOD become visible together; VALID set.
    - CONT=1: restart the counter and prescaler, go to HIGH.
    - CONT=0: go to IDLE and clear EN in hardware.
- **Timeout**
  - In HIGH or LOW, a tick while the counter = 2^CW-1 sets TIMEOUT.
  - The FSM then goes to ARM (CONT=1) or IDLE with EN cleared (CONT=0). HIGH and PERIOD are not updated.
- **Overrun**
  - A measurement completes while VALID=1: OVR is set and HIGH/PERIOD are overwritten.
- **Resulting values**
  - HIGH = floor(Nhigh/(PRESC+1)); PERIOD = floor(Nperiod/(PRESC+1)), where N counts clk cycles between detected edges.
- **Simultaneous events**
  - A flag set and a write-1-clear in the same cycle: set wins.
  - A CTRL write with EN=0: FSM goes to IDLE next cycle and no flags change.
  - A CTRL write that changes PRESC, SEL or INV while EN=1 takes effect next cycle. Firmware must re-arm to get valid results.

## Timing
- **Reset**
  - CTRL, STATUS, HIGH, PERIOD, counter, prescaler, s_prev = 0; FSM = IDLE.
  - Outputs: uo_out = 0 (with INV=0 and ui_in[0]=0), user_interrupt = 0, data_out = 0.
- **Edge latency**
  - An edge is detected in the first cycle `ui_in` shows the new level.
  - Result registers and VALID update on the clk edge that ends the detection cycle. The interrupt is visible the following cycle.
- **Writes and reads**
  - Writes commit at the clk edge of the write cycle.
  - Reads are combinational and return the pre-edge value.
- **Back-to-back periods (CONT=1)**: the closing rise is also the opening rise of the next period, so no edges are lost.
- **Reset mid-measurement**: immediate return to reset state with no partial results.

## Test plan
- **Continuous, no prescale**: PRESC=0, CONT=1, SEL=1; drive ui_in[1] high 30 cycles, low 70, repeated -> HIGH=30, PERIOD=100, VALID=1, IRQ with IE=1.
- **Prescale and single-shot**: PRESC=3, CONT=0; high 40 cycles, low 60 -> HIGH=10, PERIOD=25; EN reads 0 afterwards; further edges ignored.
- **Inverted input**: INV=1; input low 20 cycles, high 80 -> HIGH=20, PERIOD=100.
- **Timeout**: CW=8, PRESC=0; hold the input high for 300 cycles after a rise -> TIMEOUT=1 at cycle 256, HIGH/PERIOD unchanged, FSM=ARM.
- **Overrun and set-wins**: leave VALID uncleared across two periods -> OVR=1; write 1 to STATUS[0] in the completion cycle -> VALID stays 1.
- **Async reset mid-HIGH**: assert rst_n low -> all registers 0, state=IDLE, user_interrupt=0.
